// File: rtl/pc_unit.sv
// pc_unit: program counter with PC+4/branch/JALR select, misaligned-target trap,
// and an optional circular return-address stack built when PC_UNIT_RAS_EN is defined.
module pc_unit #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter logic [WIDTH-1:0] TRAP_VEC = WIDTH'(32'h0000_0100),
  parameter int RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic [1:0]       pc_src,
  input  logic [WIDTH-1:0] imm_op,
  input  logic [WIDTH-1:0] rs1_val,
  input  logic             is_call,
  input  logic             is_ret,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] pc_plus4,
  output logic             trap,
  output logic [WIDTH-1:0] trap_pc,
  output logic [WIDTH-1:0] ras_top,
  output logic             ras_valid
);
  logic [WIDTH-1:0] cand;
  logic mis;
  assign pc_plus4 = pc_out + WIDTH'(4);
  always_comb begin
    cand = pc_src == 2'b01 ? pc_out + imm_op :
           pc_src == 2'b10 ? (rs1_val + imm_op) & ~WIDTH'(1) : pc_plus4;
    mis = cand[1];
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_out <= RESET_VEC;
      trap <= 1'b0;
      trap_pc <= '0;
    end else begin
      trap <= !stall && mis;
      if (!stall) pc_out <= mis ? TRAP_VEC : cand;
      if (!stall && mis) trap_pc <= pc_out;
    end
  end
`ifdef PC_UNIT_RAS_EN
  localparam int AW = $clog2(RAS_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(RAS_DEPTH);
  logic [WIDTH-1:0] stk [RAS_DEPTH];
  logic [AW-1:0] sp, tp;
  logic [AW:0] cnt;
  logic push, pop, empty;
  assign tp = sp - AW'(1);
  assign empty = cnt == '0;
  assign push = !stall && is_call;
  assign pop = !stall && is_ret && !empty;
  // sp is the next free slot; wrapping it on a full push overwrites the oldest entry
  always_ff @(posedge clk) begin
    if (!rst) begin
      sp <= '0;
      cnt <= '0;
    end else if (push && pop) begin
      stk[tp] <= pc_plus4;
    end else if (push) begin
      stk[sp] <= pc_plus4;
      sp <= sp + AW'(1);
      cnt <= cnt == FULL ? cnt : cnt + (AW+1)'(1);
    end else if (pop) begin
      sp <= tp;
      cnt <= cnt - (AW+1)'(1);
    end
  end
  assign ras_valid = !empty;
  assign ras_top = empty ? '0 : stk[tp];
`else
  logic unused_ras;
  assign unused_ras = is_call ^ is_ret;
  assign ras_valid = 1'b0;
  assign ras_top = '0;
`endif
endmodule
